// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared 16-bit memory bus (CPU core and DMA/video fetch).
// Registered grants, one idle turnaround cycle per handover, round-robin with a hold limit.
module mem_bus_arbiter #(
    parameter int unsigned MAX_HOLD  = 8,
    parameter bit          CPU_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_r,
    input  logic        cpu_w,
    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_data_out,
    output logic        cpu_grant,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_r,
    input  logic        dma_w,
    input  logic [15:0] dma_address,
    input  logic [15:0] dma_data_out,
    output logic        dma_grant,
    output logic [15:0] mem_address,
    output logic        mem_r,
    output logic        mem_w,
    output logic [15:0] mem_data_out,
    output logic        mem_data_oe,
    output logic [15:0] read_data,
    input  logic [15:0] mem_data_in
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_DMA = 2'd2,
        TURN    = 2'd3
    } state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;
    localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    // Pretending the loser of the first tie owned the bus last makes CPU_FIRST fall out of round-robin.
    localparam logic OWNER_RST = CPU_FIRST ? OWNER_DMA : OWNER_CPU;

    state_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       last_owner_q, last_owner_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_q       <= 8'd0;
            last_owner_q <= OWNER_RST;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE, TURN: begin
                hold_d = 8'd0;
                if (cpu_req && (!dma_req || last_owner_q == OWNER_DMA)) begin
                    state_d = OWN_CPU;
                end else if (dma_req) begin
                    state_d = OWN_DMA;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN_CPU: begin
                // >= rather than == so a counter saturated during solo ownership still yields.
                if (!cpu_req || (dma_req && hold_q >= HOLD_LAST)) begin
                    state_d      = TURN;
                    last_owner_d = OWNER_CPU;
                    hold_d       = 8'd0;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            OWN_DMA: begin
                if (!dma_req || (cpu_req && hold_q >= HOLD_LAST)) begin
                    state_d      = TURN;
                    last_owner_d = OWNER_DMA;
                    hold_d       = 8'd0;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = 8'd0;
            end
        endcase
    end

    always_comb begin
        mem_address  = 16'd0;
        mem_r        = 1'b0;
        mem_w        = 1'b0;
        mem_data_out = 16'd0;
        case (state_q)
            OWN_CPU: begin
                mem_address  = cpu_address;
                mem_r        = cpu_r;
                mem_w        = cpu_w;
                mem_data_out = cpu_data_out;
            end
            OWN_DMA: begin
                mem_address  = dma_address;
                mem_r        = dma_r;
                mem_w        = dma_w;
                mem_data_out = dma_data_out;
            end
            default: begin
                mem_address  = 16'd0;
                mem_r        = 1'b0;
                mem_w        = 1'b0;
                mem_data_out = 16'd0;
            end
        endcase
    end

    assign cpu_grant   = (state_q == OWN_CPU);
    assign dma_grant   = (state_q == OWN_DMA);
    assign cpu_stall   = cpu_req & ~cpu_grant;
    assign mem_data_oe = mem_w;
    assign read_data   = mem_data_in;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 16-bit memory bus (address, data, r, w) between the Cpu core and one DMA/video-fetch master.
- Sits between both masters and the memory/peripheral decode.
- Grants are registered, and every handover passes through one turnaround cycle in which neither master drives the bus.
- Arbitration uses fixed priority on the first contention after reset, then round-robin, with a hold limit so neither master can starve the other.

Parameters:
- MAX_HOLD, 8: maximum consecutive granted cycles while the other master is requesting (legal range 1..255).
- CPU_FIRST, 1: if 1, the CPU wins a simultaneous request when no grant has yet been issued since reset; if 0, the DMA master wins.

Ports:
- clk, input, 1: system clock; all state updates on posedge.
- reset, input, 1: asynchronous, active-high reset.
- cpu_req, input, 1: CPU requests the bus; level, held until its access completes.
- cpu_r, input, 1: CPU read strobe.
- cpu_w, input, 1: CPU write strobe.
- cpu_address, input, 16: CPU address.
- cpu_data_out, input, 16: CPU write data.
- cpu_grant, output, 1: CPU owns the bus.
- cpu_stall, output, 1: cpu_req & !cpu_grant (combinational).
- dma_req, input, 1: DMA requests the bus; level.
- dma_r, input, 1: DMA read strobe.
- dma_w, input, 1: DMA write strobe.
- dma_address, input, 16: DMA address.
- dma_data_out, input, 16: DMA write data.
- dma_grant, output, 1: DMA owns the bus.
- mem_address, output, 16: bus address.
- mem_r, output, 1: bus read strobe.
- mem_w, output, 1: bus write strobe.
- mem_data_out, output, 16: bus write data.
- mem_data_oe, output, 1: data bus drive enable; equals mem_w.
- read_data, output, 16: mem_data_in passed to both masters; each master qualifies it with its own grant.
- mem_data_in, input, 16: bus read data.

Behaviour:
- States are IDLE, OWN_CPU, OWN_DMA and TURN.
- cpu_grant=1 only in OWN_CPU; dma_grant=1 only in OWN_DMA.
- Reset (async):
  - state=IDLE, both grants 0, hold_count=0, last_owner set so that CPU_FIRST decides the first tie.
  - All mem_* outputs are 0 immediately, with no clock needed.
  - Reset asserted mid-access aborts the access; no write strobe may survive the reset edge.
- Output mux (combinational from state):
  - OWN_CPU: mem_* = cpu_* signals.
  - OWN_DMA: mem_* = dma_* signals.
  - IDLE/TURN: mem_address=0, mem_r=0, mem_w=0, mem_data_out=0.
- IDLE transitions:
  - Only one req high: go to that master's OWN state. Grant is visible one clock after req is sampled high (latency 1).
  - Both high: the master that is not last_owner wins.
  - Neither high: stay in IDLE.
- OWN_x:
  - hold_count increments each cycle, saturating at MAX_HOLD.
  - Go to TURN when x_req is sampled low. The grant drops on that same edge, so a master never sees a grant one cycle after releasing.
  - Go to TURN when hold_count==MAX_HOLD-1 and the other req is high (preemption). The preempted master keeps req high and is re-granted after the other master finishes.
  - If x_req stays high and the other req is low, stay in OWN_x indefinitely; no preemption without contention.
  - On leaving, last_owner=x and hold_count=0.
- TURN:
  - Lasts exactly one cycle with the bus idle.
  - Next state follows the same rules as IDLE, except a tie always goes to the non-last_owner.
  - The same master may be re-granted if it is the only requester.
- Simultaneous events:
  - Own req drops on the same edge the limit is reached: treated as a release; result is identical (TURN).
  - Strobes from a non-granted master are ignored entirely.
- Counter width is 8 bits.
- MAX_HOLD=1 gives alternate-cycle sharing under full contention: grant, TURN, grant, and so on.
- No combinational path from any req to any grant.

Test Plan:
- Reset, then only cpu_req=1 at edge 1 -> cpu_grant=1 after edge 1. cpu_address=16'h0123 with cpu_r=1 appears on mem_address/mem_r in the same cycle, and dma_grant stays 0.
- cpu_req and dma_req both rise on the same edge with CPU_FIRST=1 -> CPU granted first. CPU releases -> one TURN cycle with mem_r=mem_w=0, then DMA granted. Both drop, then both re-request -> CPU wins (round-robin, since DMA was last owner).
- MAX_HOLD=8, dma_req held high, cpu_req rises during DMA's 3rd granted cycle -> DMA keeps the bus for 8 cycles total, TURN for 1 cycle, CPU granted. DMA is re-granted 1 cycle after cpu_req falls.
- dma_req high alone for 50 cycles -> dma_grant stays 1 throughout, no TURN cycles.
- CPU granted with cpu_w=1 and cpu_data_out=16'hBEEF; assert reset asynchronously between clock edges -> mem_w, mem_data_oe and cpu_grant go 0 before the next posedge. After reset release, the first arbitration follows CPU_FIRST.
- dma_w=1 while CPU owns the bus, with dma_address=16'h07FF -> mem_w reflects cpu_w only, and mem_address=cpu_address.
